// File: rtl/mmu_bus_arbiter.sv
// mmu_bus_arbiter
// Shared-bus stage for the MMU data path. NUM_SRC feeders request with
// valid/ready handshakes; a round-robin arbiter grants one source per cycle
// and the accepted word is queued with its source ID in a small output FIFO
// that feeds the systolic array input registers.
//
// Build option:
//   MMU_BUS_ARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest valid index wins
//                              undefined -> round-robin (default)
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   en          arbitration enable; output keeps draining while low
//   src_valid   per-source request
//   src_data    packed source words, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_ready   one-hot grant (combinational)
//   q_valid     FIFO head valid
//   q_data      FIFO head data
//   q_src       FIFO head source ID
//   q_ready     consumer accepts the head
//   fifo_count  occupancy, 0..FIFO_DEPTH

module mmu_bus_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_SRC    = 4,
  parameter int SRC_W      = $clog2(NUM_SRC),
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_SRC-1:0]            src_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_ready,
  output logic                          q_valid,
  output logic [DATA_WIDTH-1:0]         q_data,
  output logic [SRC_W-1:0]              q_src,
  input  logic                          q_ready,
  output logic [CNT_W-1:0]              fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = SRC_W + DATA_WIDTH;

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];

  logic [SRC_W-1:0]      gnt_idx;
  logic                  gnt_found;
  logic                  full;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;

`ifdef MMU_BUS_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest valid index is the last (winning) assignment.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (src_valid[k]) begin
        gnt_idx   = SRC_W'(k);
        gnt_found = 1'b1;
      end
    end
  end
`else
  logic [SRC_W-1:0] prio_q, prio_d;
  logic [SRC_W-1:0] cand_idx;
  int               cand;

  // Search prio, prio+1, ... with an explicit modulo so non-power-of-two
  // source counts wrap back to 0 instead of visiting unused indices.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = int'(prio_q) + k;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = SRC_W'(cand);
      if (!gnt_found && src_valid[cand_idx]) begin
        gnt_idx   = cand_idx;
        gnt_found = 1'b1;
      end
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (push) begin
      prio_d = (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + SRC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= '0;
    else        prio_q <= prio_d;
  end
`endif

  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  // rst_n gates the grant so src_ready reads zero for the whole reset
  // window even while requests and en are held high.
  assign push      = rst_n && en && !full && gnt_found;
  assign pop       = q_valid && q_ready;
  assign src_ready = push ? (NUM_SRC'(1) << gnt_idx) : '0;

  always_comb begin
    push_data = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (gnt_idx == SRC_W'(k)) push_data = src_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {gnt_idx, push_data};
  end

  assign q_valid         = (count_q != '0);
  assign {q_src, q_data} = mem_q[rd_ptr_q];
  assign fifo_count      = count_q;

endmodule

// File: tb/tb_mmu_bus_arbiter.sv
module tb_mmu_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [3:0]       src_valid;
  logic [3:0][63:0] sdata;
  logic [3:0]       src_ready;
  logic             q_valid;
  logic [63:0]      q_data;
  logic [1:0]       q_src;
  logic             q_ready;
  logic [2:0]       fifo_count;

  // Second instance with a non-power-of-two source count for the modulo wrap.
  logic [2:0]       v3;
  logic [23:0]      d3;
  logic [2:0]       r3;
  logic             qv3;
  logic [7:0]       qd3;
  logic [1:0]       qs3;
  logic [2:0]       cnt3;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mmu_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src_valid(src_valid), .src_data(sdata), .src_ready(src_ready),
    .q_valid(q_valid), .q_data(q_data), .q_src(q_src),
    .q_ready(q_ready), .fifo_count(fifo_count)
  );

  mmu_bus_arbiter #(.DATA_WIDTH(8), .NUM_SRC(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .src_valid(v3), .src_data(d3), .src_ready(r3),
    .q_valid(qv3), .q_data(qd3), .q_src(qs3),
    .q_ready(1'b1), .fifo_count(cnt3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; src_valid = '0; q_ready = 1'b0;
    v3 = '0; d3 = 24'h020100;
    for (int i = 0; i < 4; i++) sdata[i] = 64'(i);
    #2;
    chk("reset_count", 64'(fifo_count), 0);
    chk("reset_qvalid", 64'(q_valid), 0);
    chk("reset_ready", 64'(src_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

`ifdef MMU_BUS_ARB_FIXED_PRIO_EN
    en = 1'b1; q_ready = 1'b1; src_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1 chk("fixed_all", 64'(src_ready), 64'b0001);
      tick();
      chk("fixed_qsrc", 64'(q_src), 0);
    end
    src_valid = 4'b1000;
    #1 chk("fixed_only3", 64'(src_ready), 64'b1000);
    src_valid = 4'b1010;
    #1 chk("fixed_1_over_3", 64'(src_ready), 64'b0010);
    tick();
`else
    // Round-robin fairness, one accept and one pop per cycle.
    en = 1'b1; q_ready = 1'b1; src_valid = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1 chk("rr_ready", 64'(src_ready), 64'(4'b0001 << (i % 4)));
      tick();
      chk("rr_qvalid", 64'(q_valid), 1);
      chk("rr_qsrc", 64'(q_src), 64'(i % 4));
      chk("rr_qdata", q_data, 64'(i % 4));
    end
    src_valid = '0;
    tick();
    chk("rr_drained", 64'(q_valid), 0);

    // Wrap across a gap: prio moves to 1 first, then 3,0,3.
    src_valid = 4'b0001;
    #1 chk("gap_pre", 64'(src_ready), 64'b0001);
    tick();
    src_valid = 4'b1001;
    #1 chk("gap_g3a", 64'(src_ready), 64'b1000);
    tick();
    chk("gap_q3a", 64'(q_src), 3);
    #1 chk("gap_g0", 64'(src_ready), 64'b0001);
    tick();
    chk("gap_q0", 64'(q_src), 0);
    #1 chk("gap_g3b", 64'(src_ready), 64'b1000);
    tick();
    chk("gap_q3b", 64'(q_src), 3);
    src_valid = '0;
    tick();

    // Three sources: grants 0,2,0,2 exercise the 2 -> 0 wrap.
    v3 = 3'b101;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mod3_ready", 64'(r3), (i % 2 == 0) ? 64'b001 : 64'b100);
      tick();
      chk("mod3_qsrc", 64'(qs3), (i % 2 == 0) ? 64'd0 : 64'd2);
    end
    v3 = '0;
    tick();

    // Backpressure until full, one pop, one more grant, order preserved.
    q_ready = 1'b0; src_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      sdata[1] = 64'hA0 + 64'(i);
      #1 chk("bp_ready", 64'(src_ready), 64'b0010);
      tick();
    end
    sdata[1] = 64'hA4;
    #1 chk("bp_count_full", 64'(fifo_count), 4);
    chk("bp_ready_full", 64'(src_ready), 0);
    tick();
    chk("bp_still_full", 64'(fifo_count), 4);
    q_ready = 1'b1;
    #1 chk("bp_no_grant_on_pop", 64'(src_ready), 0);
    chk("bp_head0", q_data, 64'hA0);
    tick();
    q_ready = 1'b0;
    #1 chk("bp_count3", 64'(fifo_count), 3);
    chk("bp_regrant", 64'(src_ready), 64'b0010);
    tick();
    chk("bp_refull", 64'(fifo_count), 4);
    src_valid = '0; q_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("bp_order", q_data, 64'hA0 + 64'(i));
      tick();
    end
    chk("bp_empty", 64'(fifo_count), 0);

    // Enable gating: prio is 2 here; queue two words, then stop granting.
    sdata[1] = 64'd1;
    q_ready = 1'b0; src_valid = 4'b0110;
    #1 chk("en_g2", 64'(src_ready), 64'b0100);
    tick();
    #1 chk("en_g1", 64'(src_ready), 64'b0010);
    tick();
    chk("en_count2", 64'(fifo_count), 2);
    en = 1'b0; src_valid = 4'b1111;
    #1 chk("en_off_ready", 64'(src_ready), 0);
    q_ready = 1'b1;
    #1 chk("en_head2", 64'(q_src), 2);
    tick();
    chk("en_head1", 64'(q_src), 1);
    chk("en_count1", 64'(fifo_count), 1);
    chk("en_off_ready2", 64'(src_ready), 0);
    tick();
    chk("en_drained", 64'(fifo_count), 0);
    q_ready = 1'b0; en = 1'b1;
    #1 chk("en_resume", 64'(src_ready), 64'b0100);

    // Asynchronous reset with three entries queued.
    tick();
    tick();
    tick();
    chk("rst_pre_count", 64'(fifo_count), 3);
    rst_n = 1'b0;
    #1;
    chk("rst_async_count", 64'(fifo_count), 0);
    chk("rst_async_qvalid", 64'(q_valid), 0);
    chk("rst_async_ready", 64'(src_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_first_grant", 64'(src_ready), 64'b0001);
    tick();
    chk("rst_first_qsrc", 64'(q_src), 0);
`endif

    src_valid = '0; en = 1'b0;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
